// File: rtl/motor_cmd_sequencer.sv
// Motor command sequencer: releases one fixed-frame sender at a time, muxes its UART onto the base link,
// and enforces an inter-frame gap. Optional keep-alive retransmission is enabled by defining MOTOR_CMD_REFRESH_EN.
module motor_cmd_sequencer #(
   parameter int NUM_CMDS         = 5,
   parameter int GAP_CYCLES       = 50_000,
   parameter int IDLE_DONE_CYCLES = 4_340,
   parameter int TIMEOUT_CYCLES   = 200_000,
   parameter int REFRESH_CYCLES   = 10_000_000
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_cmd_valid,
   input  logic [2:0]          i_cmd_idx,
   input  logic [2:0]          i_speed_in,
   input  logic [NUM_CMDS-1:0] i_sender_ready,
   input  logic [NUM_CMDS-1:0] i_sender_uart,
   output logic [NUM_CMDS-1:0] o_sender_rst,
   output logic [2:0]          o_speed_out,
   output logic                o_uart_out,
   output logic                o_busy,
   output logic [2:0]          o_active_idx,
   output logic                o_timeout_err
);

   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
   localparam int IDLE_W = $clog2(IDLE_DONE_CYCLES + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [3:0] NUM_CMDS_L = 4'(NUM_CMDS);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_SENDING, S_GAP} state_t;

   state_t              r_state, w_nextState;
   logic                r_pendValid;
   logic [2:0]          r_pendIdx, r_pendSpeed;
   logic [2:0]          r_lastIdx, r_lastSpeed;
   logic [2:0]          r_activeIdx, r_speedOut;
   logic [NUM_CMDS-1:0] r_senderRst;
   logic                r_timeoutErr;
   logic                r_startSeen;
   logic [GAP_W-1:0]    r_gapCnt;
   logic [IDLE_W-1:0]   r_idleCnt;
   logic [TO_W-1:0]     r_toCnt;

   logic                w_reqLegal, w_isDup, w_reqIdle;
   logic                w_activeUart, w_activeReady;
   logic                w_idleDone, w_frameDone, w_timeoutHit, w_gapDone;
   logic                w_refreshHit;
   logic                w_launch;
   logic [2:0]          w_launchIdx, w_launchSpeed;

   assign w_reqLegal    = i_cmd_valid && ({1'b0, i_cmd_idx} < NUM_CMDS_L);
   assign w_isDup       = (i_cmd_idx == r_lastIdx) && (i_speed_in == r_lastSpeed);
   assign w_reqIdle     = w_reqLegal && !w_isDup;
   assign w_activeUart  = i_sender_uart[r_activeIdx];
   assign w_activeReady = i_sender_ready[r_activeIdx];

   // Idle-done fires on the last of IDLE_DONE_CYCLES consecutive high cycles after a start bit.
   assign w_idleDone   = w_activeUart && r_startSeen && (r_idleCnt >= IDLE_W'(IDLE_DONE_CYCLES - 1));
   assign w_frameDone  = (r_state == S_SENDING) && (w_activeReady || w_idleDone);
   assign w_timeoutHit = (r_state == S_SENDING) && (r_toCnt >= TO_W'(TIMEOUT_CYCLES - 1));
   assign w_gapDone    = (r_gapCnt >= GAP_W'(GAP_CYCLES - 1));

`ifdef MOTOR_CMD_REFRESH_EN
   localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
   logic [REF_W-1:0] r_refCnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_refCnt <= '0;
      end else if (w_launch) begin
         r_refCnt <= '0;
      end else if ((r_state == S_IDLE) && (r_refCnt != REF_W'(REFRESH_CYCLES))) begin
         r_refCnt <= r_refCnt + 1'b1;
      end
   end

   assign w_refreshHit = (r_refCnt >= REF_W'(REFRESH_CYCLES - 1));
`else
   assign w_refreshHit = 1'b0;
`endif

   // A fresh request in IDLE beats an older pending one; refresh only fires with nothing else queued.
   always_comb begin
      w_nextState   = r_state;
      w_launch      = 1'b0;
      w_launchIdx   = r_pendIdx;
      w_launchSpeed = r_pendSpeed;
      unique case (r_state)
         S_IDLE: begin
            if (w_reqIdle) begin
               w_launch      = 1'b1;
               w_launchIdx   = i_cmd_idx;
               w_launchSpeed = i_speed_in;
            end else if (r_pendValid) begin
               w_launch = 1'b1;
            end else if (w_refreshHit) begin
               w_launch      = 1'b1;
               w_launchIdx   = r_lastIdx;
               w_launchSpeed = r_lastSpeed;
            end
            if (w_launch) w_nextState = S_LAUNCH;
         end
         S_LAUNCH:  w_nextState = S_SENDING;
         S_SENDING: if (w_frameDone || w_timeoutHit) w_nextState = S_GAP;
         S_GAP:     if (w_gapDone) w_nextState = S_IDLE;
         default:   w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pendValid <= 1'b0;
         r_pendIdx   <= '0;
         r_pendSpeed <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_launch) r_pendValid <= 1'b0;
      end else if (w_reqLegal) begin
         r_pendValid <= 1'b1;
         r_pendIdx   <= i_cmd_idx;
         r_pendSpeed <= i_speed_in;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_activeIdx  <= '0;
         r_speedOut   <= '0;
         r_senderRst  <= '1;
         r_lastIdx    <= '0;
         r_lastSpeed  <= '0;
         r_timeoutErr <= 1'b0;
         r_startSeen  <= 1'b0;
         r_gapCnt     <= '0;
         r_idleCnt    <= '0;
         r_toCnt      <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_launch) begin
            r_activeIdx <= w_launchIdx;
            r_speedOut  <= w_launchSpeed;
         end
         case (r_state)
            S_LAUNCH: begin
               r_senderRst <= ~(NUM_CMDS'(1) << r_activeIdx);
               r_toCnt     <= '0;
               r_idleCnt   <= '0;
               r_startSeen <= 1'b0;
            end
            S_SENDING: begin
               if (r_toCnt != TO_W'(TIMEOUT_CYCLES)) r_toCnt <= r_toCnt + 1'b1;
               if (!w_activeUart) begin
                  r_startSeen <= 1'b1;
                  r_idleCnt   <= '0;
               end else if (r_startSeen && (r_idleCnt != IDLE_W'(IDLE_DONE_CYCLES))) begin
                  r_idleCnt <= r_idleCnt + 1'b1;
               end
               // Done takes priority over a coincident timeout; only a completed frame counts as sent.
               if (w_frameDone) begin
                  r_lastIdx   <= r_activeIdx;
                  r_lastSpeed <= r_speedOut;
               end else if (w_timeoutHit) begin
                  r_timeoutErr <= 1'b1;
               end
               if (w_frameDone || w_timeoutHit) begin
                  r_senderRst <= '1;
                  r_gapCnt    <= '0;
               end
            end
            S_GAP: begin
               if (r_gapCnt != GAP_W'(GAP_CYCLES)) r_gapCnt <= r_gapCnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_sender_rst  = r_senderRst;
   assign o_speed_out   = r_speedOut;
   assign o_uart_out    = (r_state == S_SENDING) ? w_activeUart : 1'b1;
   assign o_busy        = (r_state != S_IDLE);
   assign o_active_idx  = r_activeIdx;
   assign o_timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Testbench for motor_cmd_sequencer: stub senders with scripted line/ready timing, expected frame timing
// derived arithmetically from each stub's script. Covers MOTOR_CMD_REFRESH_EN both defined and undefined.
module tb_motor_cmd_sequencer;

   localparam int N         = 5;
   localparam int GAP       = 16;
   localparam int IDLE_DONE = 40;
   localparam int TIMEOUT   = 2000;
   localparam int REFRESH   = 500;
   localparam int NONE      = 1_000_000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cmdValid;
   logic [2:0]   cmdIdx, speedIn;
   logic [N-1:0] senderReady, senderUart, senderRst;
   logic [2:0]   speedOut, activeIdx;
   logic         uartOut, busy, timeoutErr;

   int stubDelay[N];
   int stubLen[N];
   int stubReady[N];
   int stubCnt[N];

   int checks = 0;
   int passes = 0;
   int lastIdx = 0;
   int lastSpeed = 0;
   bit expErr = 1'b0;

   motor_cmd_sequencer #(
      .NUM_CMDS(N), .GAP_CYCLES(GAP), .IDLE_DONE_CYCLES(IDLE_DONE),
      .TIMEOUT_CYCLES(TIMEOUT), .REFRESH_CYCLES(REFRESH)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmdValid), .i_cmd_idx(cmdIdx),
      .i_speed_in(speedIn), .i_sender_ready(senderReady), .i_sender_uart(senderUart),
      .o_sender_rst(senderRst), .o_speed_out(speedOut), .o_uart_out(uartOut),
      .o_busy(busy), .o_active_idx(activeIdx), .o_timeout_err(timeoutErr)
   );

   always #5 clk = ~clk;

   // Each stub counts cycles since its release; line low during [delay, delay+len), ready from readyAt on.
   always @(posedge clk) begin
      for (int k = 0; k < N; k++) stubCnt[k] <= senderRst[k] ? 0 : stubCnt[k] + 1;
   end

   always_comb begin
      senderUart  = '1;
      senderReady = '0;
      for (int k = 0; k < N; k++) begin
         if (!senderRst[k]) begin
            senderUart[k]  = !(stubCnt[k] >= stubDelay[k] && stubCnt[k] < stubDelay[k] + stubLen[k]);
            senderReady[k] = (stubCnt[k] >= stubReady[k]);
         end
      end
   end

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input int got, input int exp);
      checks++;
      if (got == exp) passes++;
      else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic applyStimulus(input int idx, input int spd);
      cmdValid = 1'b1;
      cmdIdx   = 3'(idx);
      speedIn  = 3'(spd);
      @(negedge clk);
      cmdValid = 1'b0;
   endtask

   task automatic setStub(input int k, input int d, input int len, input int rdy);
      stubDelay[k] = d;
      stubLen[k]   = len;
      stubReady[k] = rdy;
   endtask

   task automatic randomStub(input int k);
      int mode;
      mode = $urandom_range(0, 2);
      if (mode == 0)      setStub(k, $urandom_range(0, 15), $urandom_range(1, 12), NONE);
      else if (mode == 1) setStub(k, $urandom_range(0, 5), $urandom_range(1, 6), $urandom_range(3, 60));
      else                setStub(k, 0, 0, $urandom_range(1, 80));
   endtask

   // SENDING cycle (0 = first) on which the frame completes, ignoring timeout.
   function automatic int naturalDone(input int k);
      int nd;
      nd = NONE;
      if (stubLen[k] > 0) nd = stubDelay[k] + stubLen[k] - 1 + IDLE_DONE;
      if (stubReady[k] < nd) nd = stubReady[k];
      return nd;
   endfunction

   function automatic int lastSendCycle(input int k);
      return (naturalDone(k) > TIMEOUT - 1) ? TIMEOUT - 1 : naturalDone(k);
   endfunction

   // Called at the negedge inside the LAUNCH cycle; returns at the negedge of the first IDLE cycle after GAP.
   task automatic expectFrame(input int idx, input int spd);
      bit to;
      int last;
      to   = naturalDone(idx) > TIMEOUT - 1;
      last = lastSendCycle(idx);
      checkOutput("launch_busy", busy, 1);
      checkOutput("launch_rst", senderRst, 31);
      checkOutput("launch_idx", activeIdx, idx);
      checkOutput("launch_speed", speedOut, spd);
      for (int i = 0; i <= last; i++) begin
         @(negedge clk);
         checkOutput("send_rst", senderRst, 31 & ~(1 << idx));
         checkOutput("send_uart", uartOut,
                     (i >= stubDelay[idx] && i < stubDelay[idx] + stubLen[idx]) ? 0 : 1);
      end
      checkOutput("send_busy", busy, 1);
      checkOutput("send_speed", speedOut, spd);
      checkOutput("send_idx", activeIdx, idx);
      if (to) expErr = 1'b1;
      else begin
         lastIdx   = idx;
         lastSpeed = spd;
      end
      for (int g = 1; g <= GAP; g++) begin
         @(negedge clk);
         checkOutput("gap_busy", busy, 1);
         checkOutput("gap_rst", senderRst, 31);
         checkOutput("gap_uart", uartOut, 1);
         if (g == 1) checkOutput("timeout_err", timeoutErr, expErr);
      end
      @(negedge clk);
      checkOutput("idle_busy", busy, 0);
   endtask

   task automatic expectIdle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkOutput(tag, busy, 0);
      end
   endtask

   initial begin
      int idx, spd, idx2, spd2, nd;
      bit sawBusy;
      rst_n    = 1'b0;
      cmdValid = 1'b0;
      cmdIdx   = '0;
      speedIn  = '0;
      for (int k = 0; k < N; k++) setStub(k, 0, 0, NONE);
      repeat (3) @(negedge clk);
      checkOutput("rst_sender_rst", senderRst, 31);
      checkOutput("rst_uart", uartOut, 1);
      checkOutput("rst_speed", speedOut, 0);
      checkOutput("rst_idx", activeIdx, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_timeout", timeoutErr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] basic frame idx3 speed2");
      setStub(3, 2, 10, NONE);
      applyStimulus(3, 2);
      expectFrame(3, 2);

      $display("[TB] duplicate and out-of-range requests");
      applyStimulus(3, 2);
      checkOutput("dup_drop", busy, 0);
      expectIdle("dup_idle", 3);
      applyStimulus(7, 1);
      checkOutput("bad_idx_drop", busy, 0);
      expectIdle("bad_idx_idle", 3);

      $display("[TB] overwrite of pending request during SENDING");
      setStub(1, 0, 5, NONE);
      setStub(4, 3, 4, NONE);
      setStub(2, 0, 3, NONE);
      applyStimulus(1, 5);
      fork
         expectFrame(1, 5);
         begin
            repeat (3) @(negedge clk);
            applyStimulus(2, 3);
            repeat (2) @(negedge clk);
            applyStimulus(4, 6);
         end
      join
      @(negedge clk);
      expectFrame(4, 6);
      expectIdle("no_stale_pending", 5);

      $display("[TB] done and timeout coincide");
      setStub(0, 0, 0, TIMEOUT - 1);
      applyStimulus(0, 1);
      expectFrame(0, 1);

      $display("[TB] timeout frame");
      setStub(2, 0, 0, NONE);
      applyStimulus(2, 7);
      expectFrame(2, 7);
      applyStimulus(0, 1);
      checkOutput("last_kept_after_timeout", busy, 0);
      expectIdle("post_timeout_idle", 2);
      setStub(3, 1, 8, NONE);
      applyStimulus(3, 3);
      expectFrame(3, 3);
      checkOutput("timeout_sticky", timeoutErr, 1);

      $display("[TB] randomized frames");
      for (int f = 0; f < 12; f++) begin
         idx = $urandom_range(0, N - 1);
         spd = $urandom_range(0, 7);
         if (f == 3) begin
            idx = lastIdx;
            spd = lastSpeed;
         end
         randomStub(idx);
         if (idx == lastIdx && spd == lastSpeed) begin
            applyStimulus(idx, spd);
            checkOutput("rand_dup_drop", busy, 0);
            expectIdle("rand_dup_idle", 2);
         end else if ($urandom_range(0, 1) == 1) begin
            idx2 = (idx + 1 + $urandom_range(0, N - 2)) % N;
            spd2 = $urandom_range(0, 7);
            randomStub(idx2);
            nd = lastSendCycle(idx);
            applyStimulus(idx, spd);
            fork
               expectFrame(idx, spd);
               begin
                  repeat (nd + 1) @(negedge clk);
                  applyStimulus(idx2, spd2);
               end
            join
            @(negedge clk);
            expectFrame(idx2, spd2);
         end else begin
            applyStimulus(idx, spd);
            expectFrame(idx, spd);
         end
      end

      $display("[TB] reset in the middle of a frame");
      setStub(1, 0, 30, NONE);
      applyStimulus(1, 4);
      checkOutput("pre_reset_launch", busy, 1);
      repeat (10) @(negedge clk);
      checkOutput("pre_reset_uart_low", uartOut, 0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_uart", uartOut, 1);
      checkOutput("midrst_sender_rst", senderRst, 31);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_timeout", timeoutErr, 0);
      checkOutput("midrst_speed", speedOut, 0);
      lastIdx   = 0;
      lastSpeed = 0;
      expErr    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_idle", busy, 0);
      applyStimulus(0, 0);
      checkOutput("post_rst_last_cleared", busy, 0);
      setStub(3, 4, 6, 30);
      applyStimulus(3, 1);
      expectFrame(3, 1);

`ifdef MOTOR_CMD_REFRESH_EN
      $display("[TB] keep-alive relaunch");
      sawBusy = 1'b0;
      for (int j = 2; j <= REFRESH; j++) begin
         @(negedge clk);
         if (busy) sawBusy = 1'b1;
      end
      checkOutput("refresh_not_early", sawBusy, 0);
      @(negedge clk);
      expectFrame(3, 1);
`else
      $display("[TB] no keep-alive without refresh build");
      sawBusy = 1'b0;
      for (int j = 0; j < 5000; j++) begin
         @(negedge clk);
         if (busy) sawBusy = 1'b1;
      end
      checkOutput("no_refresh", sawBusy, 0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
